// File: rtl/pu_riscv_mul_serial_if.sv
// ID/EX-to-multiplier bundle: operands and instruction in, stall and result strobe back.
// The pipeline side is the master; the multiply unit is the slave.
interface pu_riscv_mul_serial_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 64
);
    logic            ex_stall;
    logic            id_bubble;
    logic [ILEN-1:0] id_instr;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [1:0]      st_xlen;
    logic            mul_stall;
    logic            mul_bubble;
    logic [XLEN-1:0] mul_r;

    modport master (
        output ex_stall, id_bubble, id_instr, opA, opB, st_xlen,
        input  mul_stall, mul_bubble, mul_r
    );

    modport slave (
        input  ex_stall, id_bubble, id_instr, opA, opB, st_xlen,
        output mul_stall, mul_bubble, mul_r
    );
endinterface

// File: rtl/pu_riscv_mul_serial.sv
// Bit-serial RV64M/RV32M multiplier: XLEN+1 busy cycles (33 for MULW), early-out on a zero operand.
// Holds the pipeline via mul_stall while busy; ignores new instructions until back in ST_CHK.
module pu_riscv_mul_serial #(
    parameter int XLEN = 64,
    parameter int ILEN = 64
) (
    input logic                  clk,
    input logic                  rst,
    pu_riscv_mul_serial_if.slave bus
);
    localparam int         CW    = $clog2(XLEN);
    localparam logic [1:0] RV32I = 2'b01;

    typedef enum logic [1:0] {ST_CHK, ST_MUL, ST_RES} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [XLEN-1:0]     mcand;
    logic [2*XLEN-1:0]   prod;
    logic                neg_q;
    logic                early;
    logic [2:0]          fmt_f3;
    logic                fmt_w;
    logic                mul_stall_q;
    logic                mul_bubble_q;
    logic [XLEN-1:0]     mul_r_q;

    // Instruction decode
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] opc;
    logic       m_ext, is_mul, is_mulh, is_mulhsu, is_mulhu, is_mulw, dec_vld;

    assign f7        = bus.id_instr[31:25];
    assign f3        = bus.id_instr[14:12];
    assign opc       = bus.id_instr[6:2];
    assign m_ext     = (f7 == 7'b0000001);
    assign is_mul    = m_ext && (f3 == 3'b000) && (opc == 5'b01100);
    assign is_mulh   = m_ext && (f3 == 3'b001) && (opc == 5'b01100);
    assign is_mulhsu = m_ext && (f3 == 3'b010) && (opc == 5'b01100);
    assign is_mulhu  = m_ext && (f3 == 3'b011) && (opc == 5'b01100);
    assign is_mulw   = m_ext && (f3 == 3'b000) && (opc == 5'b01110) && (bus.st_xlen != RV32I);
    assign dec_vld   = is_mul | is_mulh | is_mulhsu | is_mulhu | is_mulw;

    logic unused_instr;
    assign unused_instr = ^{bus.id_instr[ILEN-1:32], bus.id_instr[24:15],
                            bus.id_instr[11:7], bus.id_instr[1:0]};

    // Operand conditioning: MULW works on zero-extended low words
    logic [XLEN-1:0] op_a, op_b, mag_a, mag_b;
    logic            neg_a, neg_b, neg, zero_op;

    assign op_a    = is_mulw ? XLEN'(bus.opA[31:0]) : bus.opA;
    assign op_b    = is_mulw ? XLEN'(bus.opB[31:0]) : bus.opB;
    assign neg_a   = (is_mul | is_mulh | is_mulhsu) & op_a[XLEN-1];
    assign neg_b   = (is_mul | is_mulh) & op_b[XLEN-1];
    assign mag_a   = neg_a ? (~op_a + 1'b1) : op_a;
    assign mag_b   = neg_b ? (~op_b + 1'b1) : op_b;
    assign neg     = neg_a ^ neg_b;
    assign zero_op = (op_a == '0) || (op_b == '0);

    // Shift-add step: multiplier sits in the low half and drains out LSB first
    logic [XLEN:0] step_sum;
    assign step_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);

    // Result formatting; a 32-step run leaves the product XLEN-32 bits too high
    logic [2*XLEN-1:0] mag_p, p;
    logic [XLEN-1:0]   res;

    always_comb begin
        mag_p = fmt_w ? (prod >> (XLEN - 32)) : prod;
        p     = neg_q ? (~mag_p + 1'b1) : mag_p;
        res   = p[XLEN-1:0];
        if (fmt_f3 != 3'b000)
            res = p[2*XLEN-1:XLEN];
        else if (fmt_w)
            res = XLEN'($signed(p[31:0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_CHK;
            cnt          <= '0;
            mcand        <= '0;
            prod         <= '0;
            neg_q        <= 1'b0;
            early        <= 1'b0;
            fmt_f3       <= '0;
            fmt_w        <= 1'b0;
            mul_stall_q  <= 1'b0;
            mul_bubble_q <= 1'b1;
            mul_r_q      <= '0;
        end else begin
            if (!bus.ex_stall) begin
                fmt_f3 <= f3;
                fmt_w  <= bus.id_instr[3];
            end
            mul_bubble_q <= 1'b1;
            early        <= 1'b0;

            case (state)
                ST_CHK: begin
                    if (early) begin
                        mul_r_q      <= '0;
                        mul_bubble_q <= 1'b0;
                    end
                    if (!bus.ex_stall && !bus.id_bubble && dec_vld) begin
                        if (zero_op) begin
                            early <= 1'b1;
                        end else begin
                            mcand       <= mag_a;
                            prod        <= {{XLEN{1'b0}}, mag_b};
                            neg_q       <= neg;
                            cnt         <= is_mulw ? CW'(31) : CW'(XLEN - 1);
                            mul_stall_q <= 1'b1;
                            state       <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    prod <= {step_sum, prod[XLEN-1:1]};
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0)
                        state <= ST_RES;
                end
                ST_RES: begin
                    mul_r_q      <= res;
                    mul_bubble_q <= 1'b0;
                    mul_stall_q  <= 1'b0;
                    state        <= ST_CHK;
                end
                default: state <= ST_CHK;
            endcase
        end
    end

    assign bus.mul_stall  = mul_stall_q;
    assign bus.mul_bubble = mul_bubble_q;
    assign bus.mul_r      = mul_r_q;
endmodule
